// File: rtl/msg_sequencer_if.sv
// rtl/msg_sequencer_if.sv - request/character-stream bundle between requesters, sequencer and consumer
interface msg_sequencer_if;
    logic [3:0] req;
    logic       char_ready;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_last;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    modport master (
        output req, char_ready,
        input  char_out, char_valid, char_last, grant, busy, done
    );

    modport slave (
        input  req, char_ready,
        output char_out, char_valid, char_last, grant, busy, done
    );
endinterface

// File: rtl/msg_sequencer.sv
// rtl/msg_sequencer.sv - round-robin message sequencer streaming ROM characters with an idle gap
module msg_sequencer #(
    parameter int GAP_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    msg_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] msg_id_q, msg_id_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] char_q, char_d;
    logic       valid_q, valid_d;
    logic [3:0] grant_q, grant_d;
    logic       done_q, done_d;

    logic       found;
    logic [1:0] winner;
    logic [3:0] last_idx;
    logic       hs;

    function automatic logic [7:0] rom_char(input logic [1:0] id, input logic [3:0] i);
        logic [7:0] c;
        c = 8'h00;
        case (id)
            2'd0: case (i)
                4'd0: c = 8'h47; 4'd1: c = 8'h75; 4'd2: c = 8'h61;
                4'd3: c = 8'h74; 4'd4: c = 8'h65; 4'd5: c = 8'h6D;
                4'd6: c = 8'h61; 4'd7: c = 8'h6C; 4'd8: c = 8'h61;
                default: c = 8'h00;
            endcase
            2'd1: case (i)
                4'd0: c = 8'h51; 4'd1: c = 8'h75; 4'd2: c = 8'h65;
                4'd3: c = 8'h74; 4'd4: c = 8'h7A; 4'd5: c = 8'h61;
                4'd6: c = 8'h6C;
                default: c = 8'h00;
            endcase
            2'd2: case (i)
                4'd0: c = 8'h5A; 4'd1: c = 8'h61; 4'd2: c = 8'h63;
                4'd3: c = 8'h61; 4'd4: c = 8'h70; 4'd5: c = 8'h61;
                default: c = 8'h00;
            endcase
            default: case (i)
                4'd0: c = 8'h54; 4'd1: c = 8'h69; 4'd2: c = 8'h6B;
                4'd3: c = 8'h61; 4'd4: c = 8'h6C;
                default: c = 8'h00;
            endcase
        endcase
        return c;
    endfunction

    function automatic logic [3:0] rom_last(input logic [1:0] id);
        logic [3:0] l;
        case (id)
            2'd0:    l = 4'd8;
            2'd1:    l = 4'd6;
            2'd2:    l = 4'd5;
            default: l = 4'd4;
        endcase
        return l;
    endfunction

    // First requester at or after the rotating pointer wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && bus.req[ptr_q + 2'(i)]) begin
                found  = 1'b1;
                winner = ptr_q + 2'(i);
            end
        end
    end

    assign last_idx = rom_last(msg_id_q);
    assign hs       = valid_q & bus.char_ready;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        msg_id_d = msg_id_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        char_d   = char_q;
        valid_d  = valid_q;
        grant_d  = grant_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    msg_id_d = winner;
                    idx_d    = 4'd0;
                    char_d   = rom_char(winner, 4'd0);
                    valid_d  = 1'b1;
                    grant_d  = 4'(4'b0001 << winner);
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (idx_q != last_idx) begin
                        idx_d  = idx_q + 4'd1;
                        char_d = rom_char(msg_id_q, idx_q + 4'd1);
                    end else begin
                        valid_d = 1'b0;
                        grant_d = 4'b0000;
                        ptr_d   = msg_id_q + 2'd1;
                        done_d  = 1'b1;
                        gap_d   = 8'(GAP_CYCLES);
                        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            msg_id_q <= 2'd0;
            idx_q    <= 4'd0;
            gap_q    <= 8'd0;
            char_q   <= 8'h00;
            valid_q  <= 1'b0;
            grant_q  <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            msg_id_q <= msg_id_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    assign bus.char_out   = char_q;
    assign bus.char_valid = valid_q;
    assign bus.char_last  = valid_q && (idx_q == last_idx);
    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// tb/tb_msg_sequencer.sv - self-checking bench for msg_sequencer
module tb_msg_sequencer;

    localparam int GAP_A = 4;

    logic clk;
    logic reset;

    msg_sequencer_if bus_a ();
    msg_sequencer_if bus_b ();

    msg_sequencer #(.GAP_CYCLES(GAP_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    msg_sequencer #(.GAP_CYCLES(0))     dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          len;
        logic [71:0] str;
    } msg_rec_t;

    typedef struct packed {
        logic [7:0] ch;
        logic       last;
        logic [1:0] id;
    } exp_t;

    msg_rec_t tbl [4];
    exp_t     sb [$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int expect_gap = -1;
    int gap_run = 0;
    bit gap_armed = 0;
    bit last_hs = 0;
    bit prev_stall = 0;
    logic [7:0] prev_char;
    logic       prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] tbl_char(input int id, input int k);
        logic [71:0] s;
        s = tbl[id].str;
        return s[71-8*k -: 8];
    endfunction

    task automatic push_msg(input int id, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.ch   = tbl_char(id, k);
            e.last = (k == tbl[id].len - 1);
            e.id   = 2'(id);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int target);
        int c;
        c = 0;
        while (done_cnt < target && c < 400) begin
            @(posedge clk);
            c++;
        end
        if (done_cnt < target) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done: timeout, done_cnt %0d expected %0d", done_cnt, target);
        end
    endtask

    task automatic wait_idle_a();
        int c;
        c = 0;
        @(negedge clk);
        while (bus_a.busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("idle_a", 32'(bus_a.busy), 32'(0));
    endtask

    // Scoreboard monitor: every handshake pops one expected character.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_stall = 0;
            last_hs    = 0;
            gap_run    = 0;
            gap_armed  = 0;
        end else begin
            chk("done_pulse", 32'(bus_a.done), 32'(last_hs));
            if (bus_a.done) done_cnt++;
            if (prev_stall)
                chk("stall_hold", 32'({bus_a.char_valid, bus_a.char_out, bus_a.char_last}),
                    32'({1'b1, prev_char, prev_last}));
            if (bus_a.char_valid) begin
                if (gap_armed && expect_gap >= 0) chk("gap_len", 32'(gap_run), 32'(expect_gap));
                gap_armed = 0;
            end else begin
                gap_run++;
            end
            last_hs    = 0;
            prev_stall = 0;
            if (bus_a.char_valid && bus_a.char_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_char", 32'(bus_a.char_out), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("char", 32'(bus_a.char_out), 32'(e.ch));
                    chk("char_last", 32'(bus_a.char_last), 32'(e.last));
                    chk("grant", 32'(bus_a.grant), 32'(4'(4'b0001 << e.id)));
                    if (e.last) begin
                        last_hs   = 1;
                        gap_armed = 1;
                        gap_run   = 0;
                    end
                end
            end else if (bus_a.char_valid) begin
                prev_stall = 1;
                prev_char  = bus_a.char_out;
                prev_last  = bus_a.char_last;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  target;
        int  k;
        bit  rdy_pat [4];
        int  rr_order [5];

        tbl[0] = '{0, 9, 72'h47_75_61_74_65_6D_61_6C_61};
        tbl[1] = '{1, 7, 72'h51_75_65_74_7A_61_6C_00_00};
        tbl[2] = '{2, 6, 72'h5A_61_63_61_70_61_00_00_00};
        tbl[3] = '{3, 5, 72'h54_69_6B_61_6C_00_00_00_00};
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        rr_order = '{0, 1, 2, 3, 0};

        reset = 1'b1;
        bus_a.req = 4'b0000; bus_a.char_ready = 1'b1;
        bus_b.req = 4'b0000; bus_b.char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({bus_a.char_out, bus_a.char_valid, bus_a.char_last,
                                  bus_a.grant, bus_a.busy, bus_a.done}), 32'(0));
        reset = 1'b0;

        // Each message alone, ready held high.
        for (int t = 0; t < 4; t++) begin
            push_msg(t, tbl[t].len);
            target = done_cnt + 1;
            bus_a.req = 4'(4'b0001 << t);
            @(posedge clk);
            @(negedge clk);
            chk("latency", 32'({bus_a.char_valid, bus_a.busy}), 32'(2'b11));
            @(posedge clk);
            #1 bus_a.req = 4'b0000;
            wait_done(target);
            if (t == 0) begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (bus_a.busy && k < 20);
                chk("busy_fall", 32'(k), 32'(GAP_A));
            end
            wait_idle_a();
        end
        chk("table_drained", 32'(sb.size()), 32'(0));

        // Round-robin with all requests held.
        for (int i = 0; i < 5; i++) push_msg(rr_order[i], tbl[rr_order[i]].len);
        target = done_cnt + 5;
        bus_a.req = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        chk("rr_latency", 32'(bus_a.char_valid), 32'(1));
        @(posedge clk);
        #1 expect_gap = GAP_A + 1;
        wait_done(target);
        #1 bus_a.req = 4'b0000;
        wait_idle_a();
        expect_gap = -1;
        chk("rr_drained", 32'(sb.size()), 32'(0));

        // Backpressure on Tikal.
        push_msg(3, tbl[3].len);
        target = done_cnt + 1;
        bus_a.req = 4'b1000;
        for (int c = 0; c < 80 && done_cnt < target; c++) begin
            bus_a.char_ready = rdy_pat[c % 4];
            @(posedge clk);
            #1;
            if (c == 0) bus_a.req = 4'b0000;
        end
        chk("bp_done", 32'(done_cnt >= target), 32'(1));
        bus_a.char_ready = 1'b1;
        wait_idle_a();
        chk("bp_drained", 32'(sb.size()), 32'(0));

        // Non-preemption: switch request after two characters of Zacapa.
        push_msg(2, tbl[2].len);
        push_msg(1, tbl[1].len);
        target = done_cnt + 2;
        bus_a.req = 4'b0100;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 bus_a.req = 4'b0010;
        wait_done(target);
        #1 bus_a.req = 4'b0000;
        wait_idle_a();
        chk("np_drained", 32'(sb.size()), 32'(0));

        // Asynchronous reset in the middle of Guatemala at idx 4.
        push_msg(0, 4);
        bus_a.req = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_char", 32'({bus_a.char_valid, bus_a.char_out}), 32'({1'b1, 8'h65}));
        reset = 1'b1;
        #1;
        chk("async_reset", 32'({bus_a.char_out, bus_a.char_valid, bus_a.char_last,
                                bus_a.grant, bus_a.busy, bus_a.done}), 32'(0));
        chk("pre_reset_drained", 32'(sb.size()), 32'(0));
        push_msg(0, tbl[0].len);
        target = done_cnt + 1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("restart_char", 32'({bus_a.char_valid, bus_a.char_out}), 32'({1'b1, 8'h47}));
        @(posedge clk);
        #1 bus_a.req = 4'b0000;
        wait_done(target);
        wait_idle_a();
        chk("restart_drained", 32'(sb.size()), 32'(0));

        // Zero gap on the second instance.
        bus_b.req = 4'b0011;
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("zg_char", 32'({bus_b.char_valid, bus_b.char_out}), 32'({1'b1, tbl_char(0, i)}));
            chk("zg_last", 32'(bus_b.char_last), 32'(i == 8));
        end
        @(negedge clk);
        chk("zg_gap", 32'({bus_b.char_valid, bus_b.done}), 32'(2'b01));
        @(negedge clk);
        chk("zg_next", 32'({bus_b.char_valid, bus_b.char_out, bus_b.grant}),
            32'({1'b1, 8'h51, 4'b0010}));
        @(posedge clk);
        #1 bus_b.req = 4'b0000;
        k = 0;
        while (bus_b.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("zg_idle", 32'(bus_b.busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
